// File: rtl/census_transform_5x9.sv
// 5x9 census transform over a raster pixel stream: four line buffers feed a
// 9-column window; each center pixel yields a 45-bit "neighbour < center" descriptor.
module census_transform_5x9 #(
  parameter int FRAME_WIDTH  = 320,
  parameter int FRAME_HEIGHT = 240
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic        pix_valid,
  input  logic [7:0]  pix_data,
  input  logic [9:0]  in_x,
  input  logic [8:0]  in_y,
  output logic        in_ready,
  output logic [44:0] census,
  output logic [16:0] census_addr,
  output logic        census_valid,
  output logic        drop_flag
);
  localparam int AW   = $clog2(FRAME_WIDTH);
  localparam int ROWS = 5;
  localparam int COLS = 9;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t     state;
  logic [1:0] fcnt;
  logic [16:0] flush_base;

  // lb_mem word holds {lb3,lb2,lb1,lb0}; lb0 is the row just above the input row
  logic [3:0][7:0]             lb_mem [2**AW];
  logic [3:0][7:0]             lb_rd;
  logic [ROWS-1:0][7:0]        col;
  logic [COLS-1:0][ROWS-1:0][7:0] win;
  logic [ROWS*COLS-1:0]        cmp;

  logic        accept, border;
  logic [16:0] yc_base, run_addr;
  logic        s1_valid, s1_zero;
  logic [16:0] s1_addr;

  assign accept = pix_valid && in_ready;
  assign lb_rd  = lb_mem[in_x[AW-1:0]];
  assign col    = {pix_data, lb_rd[0], lb_rd[1], lb_rd[2], lb_rd[3]};

  assign yc_base  = 17'(in_y) * 17'(FRAME_WIDTH) - 17'(2 * FRAME_WIDTH);
  assign run_addr = yc_base + 17'(in_x) - 17'd4;
  assign border   = (in_x < 10'd8) || (in_x > 10'(FRAME_WIDTH - 1)) ||
                    (in_y < 9'd4)  || (in_y > 9'(FRAME_HEIGHT - 1));

  // win[c][r]: c=0 oldest column, r=0 top row; center at [4][2]
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      assign cmp[r*COLS+c] = win[c][r] < win[COLS/2][ROWS/2];
    end
  end

  always_ff @(posedge vga_clk) begin
    if (accept) begin
      lb_mem[in_x[AW-1:0]] <= {lb_rd[2:0], pix_data};
      win                  <= {col, win[COLS-1:1]};
    end
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      state        <= RUN;
      in_ready     <= 1'b1;
      fcnt         <= '0;
      flush_base   <= '0;
      s1_valid     <= 1'b0;
      s1_zero      <= 1'b0;
      s1_addr      <= '0;
      census       <= '0;
      census_addr  <= '0;
      census_valid <= 1'b0;
      drop_flag    <= 1'b0;
    end else begin
      census_valid <= s1_valid;
      if (s1_valid) begin
        census      <= s1_zero ? '0 : cmp;
        census_addr <= s1_addr;
      end
      if (pix_valid && !in_ready) drop_flag <= 1'b1;
      s1_valid <= 1'b0;
      if (state == RUN) begin
        if (accept) begin
          if (in_y >= 9'd2 && in_x >= 10'd4) begin
            s1_valid <= 1'b1;
            s1_zero  <= border;
            s1_addr  <= run_addr;
          end
          if (in_x == 10'(FRAME_WIDTH - 1) && in_y >= 9'd2) begin
            state      <= FLUSH;
            in_ready   <= 1'b0;
            fcnt       <= '0;
            flush_base <= yc_base + 17'(FRAME_WIDTH - 4);
          end
        end
      end else begin
        // last four centers of the row never get a right-hand neighbourhood
        s1_valid <= 1'b1;
        s1_zero  <= 1'b1;
        s1_addr  <= flush_base + 17'(fcnt);
        fcnt     <= fcnt + 2'd1;
        if (fcnt == 2'd3) begin
          state    <= RUN;
          in_ready <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_census_transform_5x9.sv
// Randomized/pattern bench for census_transform_5x9 against an image-level model.
module tb_census_transform_5x9;
  localparam int W = 320;
  localparam int H = 240;

  logic        vga_clk = 1'b0;
  logic        reset = 1'b1;
  logic        pix_valid = 1'b0;
  logic [7:0]  pix_data = '0;
  logic [9:0]  in_x = '0;
  logic [8:0]  in_y = '0;
  logic        in_ready, census_valid, drop_flag;
  logic [44:0] census;
  logic [16:0] census_addr;

  census_transform_5x9 #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H)) dut (
    .vga_clk(vga_clk), .reset(reset), .pix_valid(pix_valid), .pix_data(pix_data),
    .in_x(in_x), .in_y(in_y), .in_ready(in_ready), .census(census),
    .census_addr(census_addr), .census_valid(census_valid), .drop_flag(drop_flag)
  );

  always #5 vga_clk = ~vga_clk;

  int cyc = 0;
  always @(posedge vga_clk) cyc <= cyc + 1;

  typedef struct { int cyc; int addr; logic [44:0] cen; } ev_t;
  ev_t exp_q[$];
  ev_t obs_q[$];

  always @(negedge vga_clk)
    if (census_valid) obs_q.push_back('{cyc, int'(census_addr), census});

  byte unsigned img [H][W];
  int acc_e [16][W];
  int checks = 0;
  int passes = 0;

  function automatic logic [44:0] ref_census(int xc, int yc);
    logic [44:0] d = '0;
    if (xc < 4 || xc > W - 5 || yc < 2 || yc > H - 3) return d;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 9; c++)
        d[r*9+c] = img[yc-2+r][xc-4+c] < img[yc][xc];
    return d;
  endfunction

  task automatic model_accept(input int x, input int y, input logic [7:0] p, input int c);
    img[y][x] = p;
    if (y < 16) acc_e[y][x] = c;
    if (y >= 2 && x >= 4) exp_q.push_back('{c + 2, (y - 2) * W + x - 4, ref_census(x - 4, y - 2)});
    if (x == W - 1 && y >= 2)
      for (int k = 0; k < 4; k++) exp_q.push_back('{c + 3 + k, (y - 2) * W + W - 4 + k, 45'd0});
  endtask

  task automatic send_pixel(input int x, input int y, input logic [7:0] p, input bit polite);
    int waits = 0;
    forever begin
      @(negedge vga_clk);
      pix_data = p; in_x = 10'(x); in_y = 9'(y);
      if (in_ready) begin
        pix_valid = 1'b1;
        model_accept(x, y, p, cyc);
        break;
      end
      pix_valid = !polite;
      waits++;
      if (waits > 16) begin
        checks++;
        $display("FAIL ready_timeout x=%0d y=%0d: in_ready=%b, required 1", x, y, in_ready);
        pix_valid = 1'b0;
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge vga_clk);
      pix_valid = 1'b0;
    end
  endtask

  function automatic logic [7:0] pix_gen(int mode, int x, int y);
    case (mode)
      0: return 8'd128;
      1: return (x == 96 && y == 8) ? 8'd200 : 8'd50;
      2: if (y == 5 && x == 50) return 8'd100;
         else if (y == 5 && x == 49) return 8'd99;
         else if (y == 5 && x == 51) return 8'd100;
         else return 8'd255;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic run_frame(input int mode, input int rows, input bit polite);
    for (int y = 0; y < rows; y++)
      for (int x = 0; x < W; x++)
        send_pixel(x, y, pix_gen(mode, x, y), polite);
    idle(8);
  endtask

  function automatic int find_obs(int from, int addr);
    for (int i = from; i < obs_q.size(); i++)
      if (obs_q[i].addr == addr) return i;
    return -1;
  endfunction

  task automatic test_reset;
    repeat (3) @(negedge vga_clk);
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passes++;
    checks++; if (census_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", census_valid); else passes++;
    checks++; if (census !== 45'd0) $display("FAIL reset_census: got %h want 0", census); else passes++;
    checks++; if (census_addr !== 17'd0) $display("FAIL reset_addr: got %0d want 0", census_addr); else passes++;
    checks++; if (drop_flag !== 1'b0) $display("FAIL reset_drop: got %b want 0", drop_flag); else passes++;
    reset = 1'b0;
  endtask

  task automatic test_flat;
    int st = obs_q.size();
    int nz = 0;
    run_frame(0, 6, 1'b1);
    checks++;
    if (obs_q.size() - st != 1280) $display("FAIL flat_count: got %0d want 1280", obs_q.size() - st);
    else passes++;
    checks++;
    if (obs_q.size() <= st) $display("FAIL flat_first: got no output want addr 0");
    else if (obs_q[st].addr != 0 || obs_q[st].cyc != acc_e[2][4] + 2)
      $display("FAIL flat_first: got addr %0d cyc %0d want addr 0 cyc %0d",
               obs_q[st].addr, obs_q[st].cyc, acc_e[2][4] + 2);
    else passes++;
    for (int i = st; i < obs_q.size(); i++) if (obs_q[i].cen != 45'd0) nz++;
    checks++; if (nz != 0) $display("FAIL flat_zero: got %0d nonzero want 0", nz); else passes++;
  endtask

  task automatic test_impulse;
    int st = obs_q.size();
    int i;
    run_frame(1, 11, 1'b1);
    i = find_obs(st, 2656);
    checks++;
    if (i < 0) $display("FAIL impulse_present: got none want addr 2656");
    else if (obs_q[i].cen !== 45'h1FFFFFBFFFFF || obs_q[i].cyc != acc_e[10][100] + 2)
      $display("FAIL impulse_value: got %h cyc %0d want 1fffffbfffff cyc %0d",
               obs_q[i].cen, obs_q[i].cyc, acc_e[10][100] + 2);
    else passes++;
  endtask

  task automatic test_gradient;
    int st = obs_q.size();
    int i;
    logic [44:0] want = 45'd1 << 21;
    run_frame(2, 8, 1'b1);
    i = find_obs(st, 1650);
    checks++;
    if (i < 0) $display("FAIL gradient_present: got none want addr 1650");
    else if (obs_q[i].cen !== want) $display("FAIL gradient_value: got %h want %h", obs_q[i].cen, want);
    else passes++;
  endtask

  task automatic test_flush_drop;
    int st = obs_q.size();
    int i, a;
    checks++; if (drop_flag !== 1'b0) $display("FAIL drop_pre: got %b want 0", drop_flag); else passes++;
    run_frame(3, 8, 1'b0);
    checks++; if (drop_flag !== 1'b1) $display("FAIL drop_set: got %b want 1", drop_flag); else passes++;
    a = acc_e[5][319];
    checks++;
    if (acc_e[6][0] != a + 5) $display("FAIL flush_next_accept: got cyc %0d want %0d", acc_e[6][0], a + 5);
    else passes++;
    for (int k = 0; k < 4; k++) begin
      i = find_obs(st, 1276 + k);
      checks++;
      if (i < 0) $display("FAIL flush_out%0d: got none want addr %0d", k, 1276 + k);
      else if (obs_q[i].cyc != a + 3 + k || obs_q[i].cen !== 45'd0)
        $display("FAIL flush_out%0d: got cyc %0d census %h want cyc %0d census 0",
                 k, obs_q[i].cyc, obs_q[i].cen, a + 3 + k);
      else passes++;
    end
    i = find_obs(st, 326);
    checks++;
    if (i < 0) $display("FAIL border_present: got none want addr 326");
    else if (obs_q[i].cen !== 45'd0 || obs_q[i].cyc != acc_e[3][10] + 2)
      $display("FAIL border_value: got %h cyc %0d want 0 cyc %0d", obs_q[i].cen, obs_q[i].cyc, acc_e[3][10] + 2);
    else passes++;
  endtask

  task automatic test_scoreboard;
    int bad = 0;
    checks++;
    if (obs_q.size() != exp_q.size()) $display("FAIL sb_count: got %0d want %0d", obs_q.size(), exp_q.size());
    else passes++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size() && bad < 10; i++) begin
      checks++;
      if (obs_q[i].cyc != exp_q[i].cyc || obs_q[i].addr != exp_q[i].addr || obs_q[i].cen !== exp_q[i].cen) begin
        bad++;
        $display("FAIL sb_entry%0d: got cyc %0d addr %0d census %h want cyc %0d addr %0d census %h", i,
                 obs_q[i].cyc, obs_q[i].addr, obs_q[i].cen, exp_q[i].cyc, exp_q[i].addr, exp_q[i].cen);
      end else passes++;
    end
  endtask

  task automatic test_reset_flush;
    int c, n, guard;
    obs_q.delete(); exp_q.delete();
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < W; x++)
        send_pixel(x, y, 8'($urandom_range(0, 255)), 1'b1);
    c = acc_e[2][319];
    @(negedge vga_clk); pix_valid = 1'b1;
    guard = 0;
    while (cyc < c + 4 && guard < 20) begin @(negedge vga_clk); guard++; end
    #2;
    checks++;
    if (obs_q.size() == 0 || obs_q[$].addr != 317)
      $display("FAIL rstf_pre: got %0d outputs last addr %0d want last addr 317",
               obs_q.size(), obs_q.size() ? obs_q[$].addr : -1);
    else passes++;
    reset = 1'b1;
    #1;
    checks++; if (census_valid !== 1'b0) $display("FAIL rstf_valid: got %b want 0", census_valid); else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL rstf_ready: got %b want 1", in_ready); else passes++;
    checks++; if (drop_flag !== 1'b0) $display("FAIL rstf_drop: got %b want 0", drop_flag); else passes++;
    @(negedge vga_clk);
    pix_valid = 1'b0;
    reset = 1'b0;
    n = obs_q.size();
    idle(10);
    checks++;
    if (obs_q.size() != n) $display("FAIL rstf_no_flush: got %0d extra outputs want 0", obs_q.size() - n);
    else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL rstf_ready_after: got %b want 1", in_ready); else passes++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_flat();
    test_impulse();
    test_gradient();
    test_flush_drop();
    test_scoreboard();
    test_reset_flush();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
